// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/lz_blank.sv
// Leading-zero blank mask: bit k set when digit k and all higher digits are zero (k > 0).
module lz_blank
  import seg_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic [4*NDIGITS-1:0] i_bcd,
  input  logic                 i_lz,
  output logic [NDIGITS-1:0]   o_mask
);

  logic w_zero_above;

  always_comb begin
    w_zero_above = 1'b1;
    o_mask       = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (bcd_digit_t'(i_bcd[4*k +: 4]) == 4'h0);
      o_mask[k]    = i_lz && w_zero_above && (k != 0);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed digit scanner: pending/display registers, prescaler, digit index and
// output decode. New values are swapped in only at frame boundaries.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned DIV     = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] in_bcd,
  input  logic                 in_blank_lz,
  output logic [3:0]           data,
  output logic [NDIGITS-1:0]   digit_en
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  scan_state_t          r_state, w_state_nxt;
  logic                 r_pend_v;
  logic [4*NDIGITS-1:0] r_pend_bcd;
  logic                 r_pend_lz;
  logic [4*NDIGITS-1:0] r_disp_bcd;
  logic                 r_disp_lz;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;

  logic                 w_tick;
  logic                 w_frame_end;
  logic                 w_xfer;
  logic                 w_accept;
  logic [NDIGITS-1:0]   w_mask;
  bcd_digit_t           w_nib;
  logic                 w_blank;

  assign w_tick      = (r_cnt == CW'(DIV - 1));
  // IDLE counts as a permanent frame boundary so the first value goes straight to display
  assign w_frame_end = (r_state == IDLE) || (w_tick && (r_idx == IW'(NDIGITS - 1)));
  assign w_xfer      = w_frame_end && r_pend_v;
  assign in_ready    = !r_pend_v || w_xfer;
  assign w_accept    = in_valid && in_ready;

  lz_blank #(
    .NDIGITS(NDIGITS)
  ) u_lz_blank (
    .i_bcd (r_disp_bcd),
    .i_lz  (r_disp_lz),
    .o_mask(w_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend_v   <= 1'b0;
      r_pend_bcd <= '0;
      r_pend_lz  <= 1'b0;
      r_disp_bcd <= '0;
      r_disp_lz  <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_disp_bcd <= r_pend_bcd;
        r_disp_lz  <= r_pend_lz;
      end
      if (w_accept) begin
        r_pend_v   <= 1'b1;
        r_pend_bcd <= in_bcd;
        r_pend_lz  <= in_blank_lz;
      end else if (w_xfer) begin
        r_pend_v <= 1'b0;
      end
      if (r_state == SCAN) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          r_idx <= (r_idx == IW'(NDIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
      end else begin
        r_cnt <= '0;
        r_idx <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_nib       = BLANK;
    w_blank     = 1'b0;
    data        = BLANK;
    digit_en    = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib   = r_disp_bcd[4*k +: 4];
        w_blank = w_mask[k];
      end
    end
    unique case (r_state)
      IDLE: begin
        if (w_xfer) w_state_nxt = SCAN;
      end
      SCAN: begin
        data = w_blank ? BLANK : w_nib;
        // first cycle of each dwell is a dark guard cycle against ghosting
        if (r_cnt != '0) digit_en = NDIGITS'(1) << r_idx;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a frame-position reference model.
module tb_seg_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned DV    = 4;
  localparam int unsigned FRAME = ND * DV;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4*ND-1:0] in_bcd;
  logic            in_blank_lz;
  logic [3:0]      data;
  logic [ND-1:0]   digit_en;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: scanning flag, position within the frame, one pending slot, display value
  bit              m_scan;
  int              m_pos;
  bit              m_pend_v;
  logic [4*ND-1:0] m_pend_b;
  bit              m_pend_lz;
  logic [4*ND-1:0] m_disp_b;
  bit              m_disp_lz;
  bit              m_accepted;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NDIGITS(ND),
    .DIV    (DV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .in_blank_lz(in_blank_lz),
    .data       (data),
    .digit_en   (digit_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan    = 0;
    m_pos     = 0;
    m_pend_v  = 0;
    m_pend_b  = '0;
    m_pend_lz = 0;
    m_disp_b  = '0;
    m_disp_lz = 0;
  endtask

  // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input bit v, input logic [4*ND-1:0] b, input bit lz, input bit r);
    int              d;
    logic [4*ND-1:0] upper;
    logic [3:0]      e_data;
    logic [ND-1:0]   e_en;
    bit              e_fe;
    bit              e_ready;
    in_valid    = v;
    in_bcd      = b;
    in_blank_lz = lz;
    rst_n       = r;
    #2;
    e_fe    = !m_scan || (m_pos == FRAME - 1);
    e_ready = !m_pend_v || (e_fe && m_pend_v);
    if (!m_scan) begin
      e_data = 4'hF;
      e_en   = '0;
    end else begin
      d      = m_pos / DV;
      upper  = m_disp_b >> (4 * d);
      e_data = (m_disp_lz && d != 0 && upper == '0) ? 4'hF : upper[3:0];
      e_en   = (m_pos % DV == 0) ? '0 : ND'(1) << d;
    end
    check("data", 32'(data), 32'(e_data));
    check("digit_en", 32'(digit_en), 32'(e_en));
    check("in_ready", 32'(in_ready), 32'(e_ready));
    @(posedge clk);
    m_accepted = 0;
    if (!r) begin
      model_reset();
    end else begin
      if (e_fe && m_pend_v) begin
        m_disp_b  = m_pend_b;
        m_disp_lz = m_pend_lz;
        m_pend_v  = 0;
        m_scan    = 1;
        m_pos     = 0;
      end else if (m_scan) begin
        m_pos = (m_pos + 1) % FRAME;
      end
      if (v && e_ready) begin
        m_pend_v   = 1;
        m_pend_b   = b;
        m_pend_lz  = lz;
        m_accepted = 1;
      end
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 1);
  endtask

  task automatic send(input logic [4*ND-1:0] b, input bit lz);
    int budget = 0;
    m_accepted = 0;
    while (!m_accepted && budget < 100) begin
      cycle(1, b, lz, 1);
      budget++;
    end
    check("send_accept_timeout", 32'(m_accepted), 32'd1);
  endtask

  function automatic logic [4*ND-1:0] rand_bcd();
    logic [4*ND-1:0] v;
    for (int k = 0; k < ND; k++) begin
      case ($urandom_range(0, 3))
        0:       v[4*k +: 4] = 4'h0;
        1:       v[4*k +: 4] = 4'($urandom_range(10, 15));
        default: v[4*k +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  initial begin
    int budget;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bcd      = '0;
    in_blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(0, '0, 0, 0);
    idle_cycles(3);

    send(16'h1234, 0);
    idle_cycles(FRAME + 4);
    send(16'h0070, 1);
    idle_cycles(2 * FRAME);
    send(16'h0000, 1);
    idle_cycles(2 * FRAME);
    send(16'hF9A0, 0);
    idle_cycles(2 * FRAME);

    // back-to-back values with a third held valid until the frame boundary
    idle_cycles(5);
    send(16'h1111, 0);
    send(16'h2222, 0);
    send(16'h3333, 0);
    idle_cycles(2 * FRAME);

    // reset during digit 2
    budget = 0;
    while (!(m_scan && m_pos == 2 * DV + 1) && budget < 2 * FRAME) begin
      cycle(0, '0, 0, 1);
      budget++;
    end
    check("reach_digit2", 32'(m_pos), 32'(2 * DV + 1));
    cycle(0, '0, 0, 0);
    idle_cycles(3);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 7) == 0), rand_bcd(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 399) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
